// File: rtl/shuffle_ctrl.sv
// Sequencer for the 10-bit number-shuffle datapath: captures a pattern, runs ROUNDS
// permute+rotate rounds driven by an on-chip LFSR, returns the result via valid/ack.
// Optional build macro SHUFFLE_CTRL_RESEED_EN adds a runtime LFSR reseed port.
module shuffle_ctrl #(
    parameter int unsigned ROUNDS = 3,
    parameter logic [9:0]  SEED   = 10'h2A5
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       I_START,
    input  logic [9:0] I_NUM,
    input  logic       I_ACK,
`ifdef SHUFFLE_CTRL_RESEED_EN
    input  logic       I_SEED_LD,
    input  logic [9:0] I_SEED,
`endif
    output logic       O_BUSY,
    output logic       O_VALID,
    output logic [9:0] O_NUM,
    output logic [3:0] O_ROT
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t     state_q, state_d;
    logic [9:0] lfsr_q, lfsr_d;
    logic [9:0] d_q, d_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] num_q, num_d;
    logic [3:0] rot_q, rot_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    logic [3:0] amt;
    logic [9:0] round_res;

    function automatic logic [9:0] perm(input logic [9:0] x);
        return {x[1], x[3], x[7], x[9], x[2], x[0], x[8], x[5], x[6], x[4]};
    endfunction

    // Fold 10..15 back into 0..5 so the rotate never reaches a full turn.
    function automatic logic [3:0] rot_amt(input logic [9:0] l);
        return (l[3:0] >= 4'd10) ? (l[3:0] - 4'd10) : l[3:0];
    endfunction

    function automatic logic [9:0] rotl10(input logic [9:0] x, input logic [3:0] a);
        logic [19:0] t;
        t = {x, x} << a;
        return t[19:10];
    endfunction

    always_comb begin
        // Shift toward the MSB; taps 10 and 7 feed bit 0. All-zero recovers to SEED.
        lfsr_d = (lfsr_q == 10'd0) ? SEED : {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
`ifdef SHUFFLE_CTRL_RESEED_EN
        if (I_SEED_LD)
            lfsr_d = (I_SEED == 10'd0) ? SEED : I_SEED;
`endif
    end

    assign amt       = rot_amt(lfsr_q);
    assign round_res = rotl10(perm(d_q), amt);

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rot_d   = rot_q;
        case (state_q)
            IDLE: begin
                if (I_START) begin
                    d_d     = I_NUM;
                    cnt_d   = 4'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                d_d   = round_res;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    num_d   = round_res;
                    rot_d   = amt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (I_ACK)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            d_q     <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            rot_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rot_q   <= rot_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign O_BUSY  = busy_q;
    assign O_VALID = valid_q;
    assign O_NUM   = num_q;
    assign O_ROT   = rot_q;

endmodule

// File: tb/tb_shuffle_ctrl.sv
// Directed/randomised checks of shuffle_ctrl with ROUNDS=1 and ROUNDS=8 instances.
module tb_shuffle_ctrl;

    localparam logic [9:0] SEED = 10'h2A5;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       start1 = 0, ack1 = 0, start8 = 0, ack8 = 0;
    logic [9:0] num1 = '0, num8 = '0;
    logic       v1, b1, v8, b8;
    logic [9:0] n1, n8;
    logic [3:0] r1, r8;
`ifdef SHUFFLE_CTRL_RESEED_EN
    logic       seed_ld = 1'b0;
    logic [9:0] seed = '0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    shuffle_ctrl #(.ROUNDS(1), .SEED(SEED)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .I_START(start1), .I_NUM(num1), .I_ACK(ack1),
`ifdef SHUFFLE_CTRL_RESEED_EN
        .I_SEED_LD(seed_ld), .I_SEED(seed),
`endif
        .O_BUSY(b1), .O_VALID(v1), .O_NUM(n1), .O_ROT(r1)
    );

    shuffle_ctrl #(.ROUNDS(8), .SEED(SEED)) u_dut8 (
        .CLK(CLK), .RSTN(RSTN), .I_START(start8), .I_NUM(num8), .I_ACK(ack8),
`ifdef SHUFFLE_CTRL_RESEED_EN
        .I_SEED_LD(seed_ld), .I_SEED(seed),
`endif
        .O_BUSY(b8), .O_VALID(v8), .O_NUM(n8), .O_ROT(r8)
    );

    // Reference LFSR, x^10+x^7+1 shifting toward the MSB.
    logic [9:0] lfsr_m;
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) lfsr_m <= SEED;
`ifdef SHUFFLE_CTRL_RESEED_EN
        else if (seed_ld) lfsr_m <= (seed == 10'd0) ? SEED : seed;
`endif
        else if (lfsr_m == 10'd0) lfsr_m <= SEED;
        else lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    function automatic logic [3:0] amt_of(input logic [9:0] l);
        logic [3:0] lo;
        lo = l[3:0];
        if (lo > 4'd9) lo = lo - 4'd10;
        return lo;
    endfunction

    function automatic logic [9:0] perm_m(input logic [9:0] x);
        int src [10] = '{1, 3, 7, 9, 2, 0, 8, 5, 6, 4};
        logic [9:0] y;
        y = '0;
        for (int i = 0; i < 10; i++) y[9 - i] = x[src[i]];
        return y;
    endfunction

    function automatic logic [9:0] rotl_m(input logic [9:0] x, input logic [3:0] a);
        logic [9:0] y;
        y = x;
        for (int i = 0; i < int'(a); i++) y = {y[8:0], y[9]};
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit big, input logic s, input logic [9:0] n, input logic a);
        if (big) begin start8 = s; num8 = n; ack8 = a; end
        else     begin start1 = s; num1 = n; ack1 = a; end
    endtask

    // One request: accept, model every round from the reference LFSR, hold, then ack.
    task automatic req(input bit big, input logic [9:0] num, input int dly, input bit spur,
                       output logic [9:0] got_n, output logic [3:0] got_r);
        int         rounds;
        logic [9:0] d;
        logic [3:0] a;
        rounds = big ? 8 : 1;
        d = num;
        a = '0;
        drive(big, 1'b1, num, 1'b0);
        @(posedge CLK); #1;
        chk("busy_on_accept", big ? b8 : b1, 1);
        for (int k = 0; k < rounds; k++) begin
            drive(big, spur && (k == 0), 10'($urandom), 1'b0);
            chk("valid_early", big ? v8 : v1, 0);
            a = amt_of(lfsr_m);
            d = rotl_m(perm_m(d), a);
            @(posedge CLK); #1;
        end
        got_n = big ? n8 : n1;
        got_r = big ? r8 : r1;
        chk("valid_on_time", big ? v8 : v1, 1);
        chk("num", got_n, d);
        chk("rot", got_r, a);
        chk("popcount", $countones(got_n), $countones(num));
        chk("rot_le9", got_r <= 4'd9, 1);
        drive(big, 1'b0, 10'($urandom), 1'b0);
        for (int i = 0; i < dly; i++) begin
            @(posedge CLK); #1;
            chk("hold_valid", big ? v8 : v1, 1);
            chk("hold_num", big ? n8 : n1, d);
        end
        drive(big, spur, 10'($urandom), 1'b1);
        @(posedge CLK); #1;
        drive(big, 1'b0, 10'($urandom), 1'b0);
        chk("ack_valid", big ? v8 : v1, 0);
        chk("ack_busy", big ? b8 : b1, 0);
        chk("num_after_ack", big ? n8 : n1, d);
    endtask

    initial begin
        logic [9:0] gn, gn_a;
        logic [3:0] gr, gr_a;

        #2;
        chk("rst_dut1", {v1, b1, r1, n1}, 0);
        chk("rst_dut8", {v8, b8, r8, n8}, 0);
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            chk("idle_dut1", {v1, b1, r1, n1}, 0);
        end
        chk("idle_dut8", {v8, b8, r8, n8}, 0);

        req(1'b0, 10'h001, 0, 1'b0, gn, gr);
        chk("onehot", gn, rotl_m(10'h010, gr));
        req(1'b0, 10'h000, 2, 1'b0, gn, gr);
        chk("all_zero", gn, 10'h000);
        req(1'b0, 10'h3FF, 1, 1'b1, gn, gr);
        chk("all_ones", gn, 10'h3FF);
        req(1'b0, 10'h2C1, 3, 1'b1, gn, gr);
        req(1'b1, 10'h155, 2, 1'b1, gn, gr);

        for (int i = 0; i < 1000; i++)
            req(1'b0, 10'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)), gn, gr);
        for (int i = 0; i < 60; i++)
            req(1'b1, 10'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)), gn, gr);

        // Abort mid-ROUND: reset after the fourth round edge.
        drive(1'b1, 1'b1, 10'h0F3, 1'b0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 10'h0F3, 1'b0);
        repeat (4) @(posedge CLK);
        #1 RSTN = 1'b0;
        #1;
        chk("abort_busy", b8, 0);
        chk("abort_outs", {v8, b8, r8, n8}, 0);
        @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("abort_no_valid", {v8, b8}, 0);
        end
        @(posedge CLK); #1;
        #0;

        // Same request right after a reset release and right after a reseed to SEED.
        RSTN = 1'b0;
        #1;
        @(posedge CLK);
        #1 RSTN = 1'b1;
        req(1'b1, 10'h1B3, 0, 1'b0, gn_a, gr_a);
`ifdef SHUFFLE_CTRL_RESEED_EN
        repeat (5) @(posedge CLK);
        #1;
        seed_ld = 1'b1;
        seed = 10'h2A5;
        @(posedge CLK); #1;
        seed_ld = 1'b0;
        req(1'b1, 10'h1B3, 0, 1'b0, gn, gr);
        chk("reseed_num", gn, gn_a);
        chk("reseed_rot", gr, gr_a);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
